// File: rtl/ov7670_capture_scaler.sv
// OV7670 byte-stream capture: pairs bytes into 12-bit pixels, decimates 1:1/1:2/1:4,
// and writes a packed image into one of two ping-pong frame-buffer banks.
module ov7670_capture_scaler #(
    parameter int SRC_WIDTH  = 640,
    parameter int SRC_HEIGHT = 480,
    parameter int ADDR_W     = 19
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        din,
    input  logic              fmt,
    input  logic [1:0]        decim,
    input  logic              pause,
    output logic [ADDR_W-1:0] addr,
    output logic [11:0]       dout,
    output logic              we,
    output logic              bank,
    output logic              frame_done,
    output logic              line_err
);

    localparam int CW = ($clog2(SRC_WIDTH + 1) < 2) ? 2 : $clog2(SRC_WIDTH + 1);
    localparam int RW = ($clog2(SRC_HEIGHT + 1) < 2) ? 2 : $clog2(SRC_HEIGHT + 1);
    localparam logic [CW-1:0] W_LIM = CW'(SRC_WIDTH);
    localparam logic [RW-1:0] H_LIM = RW'(SRC_HEIGHT);

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_SKIP   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              href_q, href_d;
    logic              phase_q, phase_d;
    logic [7:0]        hi_q, hi_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic              fmt_q, fmt_d;
    logic [1:0]        decim_q, decim_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [11:0]       dout_q, dout_d;
    logic              we_q, we_d;
    logic              bank_q, bank_d;
    logic              frame_done_q, frame_done_d;
    logic              line_err_q, line_err_d;

    logic              capturing_s;
    logic [1:0]        mask_s;
    logic              keep_s;
    logic [11:0]       pix_s;

    // Pixel assembly, decimation test, next-state and output logic
    always_comb begin
        state_d      = state_q;
        href_d       = href;
        phase_d      = phase_q;
        hi_d         = hi_q;
        col_d        = col_q;
        row_d        = row_q;
        fmt_d        = fmt_q;
        decim_d      = decim_q;
        ptr_d        = ptr_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        we_d         = 1'b0;
        bank_d       = bank_q;
        frame_done_d = 1'b0;
        line_err_d   = line_err_q;

        case (decim_q)
            2'd0:    mask_s = 2'b00;
            2'd1:    mask_s = 2'b01;
            default: mask_s = 2'b11;
        endcase

        keep_s = (row_q < H_LIM) && ((col_q[1:0] & mask_s) == 2'b00)
                 && ((row_q[1:0] & mask_s) == 2'b00);

        if (fmt_q) begin
            pix_s = {hi_q[3:0], din};
        end else begin
            pix_s = {hi_q[7:4], hi_q[2:0], din[7], din[4:1]};
        end

        // A rising vsync ends the frame immediately, so bytes seen with vsync high are ignored.
        capturing_s = ((state_q == ST_ACTIVE) || (state_q == ST_SKIP)) && !vsync;

        case (state_q)
            ST_SYNC: begin
                if (vsync) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_WAIT: begin
                if (!vsync) begin
                    state_d = pause ? ST_SKIP : ST_ACTIVE;
                    fmt_d   = fmt;
                    decim_d = decim;
                    col_d   = {CW{1'b0}};
                    row_d   = {RW{1'b0}};
                    ptr_d   = {ADDR_W{1'b0}};
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ACTIVE: begin
                if (vsync) begin
                    state_d      = ST_WAIT;
                    frame_done_d = 1'b1;
                    bank_d       = ~bank_q;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_SKIP: begin
                if (vsync) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_SKIP;
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase

        if (capturing_s) begin
            if (href) begin
                if (!phase_q) begin
                    hi_d    = din;
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    // Column saturates at the limit so overlong lines never wrap back into range.
                    if (col_q < W_LIM) begin
                        col_d = col_q + CW'(1);
                        if ((state_q == ST_ACTIVE) && keep_s) begin
                            we_d   = 1'b1;
                            addr_d = ptr_q;
                            dout_d = pix_s;
                            ptr_d  = ptr_q + ADDR_W'(1);
                        end else begin
                            we_d = 1'b0;
                        end
                    end else begin
                        line_err_d = line_err_q | (state_q == ST_ACTIVE);
                    end
                end
            end else begin
                phase_d = 1'b0;
                if (href_q) begin
                    col_d = {CW{1'b0}};
                    if (row_q < H_LIM) begin
                        row_d = row_q + RW'(1);
                    end else begin
                        row_d = row_q;
                    end
                end else begin
                    col_d = col_q;
                end
            end
        end else begin
            phase_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_SYNC;
            href_q       <= 1'b0;
            phase_q      <= 1'b0;
            hi_q         <= 8'h00;
            col_q        <= {CW{1'b0}};
            row_q        <= {RW{1'b0}};
            fmt_q        <= 1'b0;
            decim_q      <= 2'd0;
            ptr_q        <= {ADDR_W{1'b0}};
            addr_q       <= {ADDR_W{1'b0}};
            dout_q       <= 12'h000;
            we_q         <= 1'b0;
            bank_q       <= 1'b0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            href_q       <= href_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            col_q        <= col_d;
            row_q        <= row_d;
            fmt_q        <= fmt_d;
            decim_q      <= decim_d;
            ptr_q        <= ptr_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            we_q         <= we_d;
            bank_q       <= bank_d;
            frame_done_q <= frame_done_d;
            line_err_q   <= line_err_d;
        end
    end

    assign addr       = addr_q;
    assign dout       = dout_q;
    assign we         = we_q;
    assign bank       = bank_q;
    assign frame_done = frame_done_q;
    assign line_err   = line_err_q;

endmodule

// File: tb/tb_ov7670_capture_scaler.sv
// Scoreboard bench for ov7670_capture_scaler on an 8x4 source: the driver queues
// expected writes, a negedge monitor pops and compares them.
module tb_ov7670_capture_scaler;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        fmt = 1'b0;
    logic [1:0]  decim = 2'd0;
    logic        pause = 1'b0;
    logic [18:0] addr;
    logic [11:0] dout;
    logic        we;
    logic        bank;
    logic        frame_done;
    logic        line_err;

    int checks = 0;
    int failures = 0;
    int fd_count = 0;
    int exp_fd = 0;
    logic exp_bank = 1'b0;
    logic [18:0] sb_addr[$];
    logic [11:0] sb_dout[$];

    ov7670_capture_scaler #(.SRC_WIDTH(8), .SRC_HEIGHT(4), .ADDR_W(19)) dut (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .din(din),
        .fmt(fmt), .decim(decim), .pause(pause), .addr(addr), .dout(dout),
        .we(we), .bank(bank), .frame_done(frame_done), .line_err(line_err)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard
    always @(negedge pclk) begin
        if (we) begin
            if (sb_addr.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_we: got addr 0x%0h dout 0x%0h expected no write", addr, dout);
            end else begin
                chk("wr_addr", 32'(addr), 32'(sb_addr.pop_front()));
                chk("wr_dout", 32'(dout), 32'(sb_dout.pop_front()));
            end
        end
        if (frame_done) fd_count++;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            href = 1'b0;
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_addr", 32'(addr), 32'h0);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_we", 32'(we), 32'h0);
        chk("rst_bank", 32'(bank), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_line_err", 32'(line_err), 32'h0);
    endtask

    // One 4-line frame; stop_after>=0 pulses reset right after that many writes.
    task automatic run_frame(input logic f, input logic [1:0] d, input logic p,
                             input logic [7:0] hi, input logic [7:0] lo,
                             input logic [11:0] exp_dout, input int long_row,
                             input int stop_after);
        int dd;
        int nw;
        int len;
        logic [18:0] ea;
        logic did_rst;
        dd = (d == 2'd0) ? 1 : ((d == 2'd1) ? 2 : 4);
        nw = 0;
        ea = 19'd0;
        did_rst = 1'b0;
        @(negedge pclk);
        vsync = 1'b1;
        href = 1'b0;
        idle(3);
        fmt = f;
        decim = d;
        pause = p;
        @(negedge pclk);
        vsync = 1'b0;
        idle(2);
        for (int r = 0; r < 4; r++) begin
            len = (r == long_row) ? 10 : 8;
            for (int c = 0; c < len; c++) begin
                @(negedge pclk);
                href = 1'b1;
                din = hi;
                @(negedge pclk);
                din = lo;
                if (!p && (r % dd == 0) && (c % dd == 0) && (c < 8)
                    && (stop_after < 0 || nw < stop_after)) begin
                    sb_addr.push_back(ea);
                    sb_dout.push_back(exp_dout);
                    ea = ea + 19'd1;
                    nw++;
                end
                if (stop_after >= 0 && nw == stop_after && !did_rst) begin
                    @(negedge pclk);
                    href = 1'b0;
                    #2;
                    rst_n = 1'b0;
                    #1;
                    check_reset_outputs();
                    #2;
                    rst_n = 1'b1;
                    did_rst = 1'b1;
                end
            end
            @(negedge pclk);
            href = 1'b0;
            idle(2);
            if (r == 0) begin
                decim = ~d;
                fmt = ~f;
            end
        end
        @(negedge pclk);
        vsync = 1'b1;
        idle(4);
        if (stop_after >= 0) begin
            exp_bank = 1'b0;
        end else if (!p) begin
            exp_fd++;
            exp_bank = ~exp_bank;
        end
        chk("frame_done_count", 32'(fd_count), 32'(exp_fd));
        chk("bank", 32'(bank), 32'(exp_bank));
        chk("scoreboard_drained", 32'(sb_addr.size()), 32'h0);
    endtask

    initial begin
        #3;
        check_reset_outputs();
        #20;
        rst_n = 1'b1;
        // Full-rate RGB565: 32 writes of 0xF0F
        run_frame(1'b0, 2'd0, 1'b0, 8'hF8, 8'h1F, 12'hF0F, -1, -1);
        // 1:2 and 1:4 decimation
        run_frame(1'b0, 2'd1, 1'b0, 8'hA5, 8'h5A, 12'hAAD, -1, -1);
        run_frame(1'b0, 2'd2, 1'b0, 8'hA5, 8'h5A, 12'hAAD, -1, -1);
        // RGB444
        run_frame(1'b1, 2'd0, 1'b0, 8'h0A, 8'hBC, 12'hABC, -1, -1);
        // Paused frame, then resume in the same bank
        run_frame(1'b0, 2'd0, 1'b1, 8'hF8, 8'h1F, 12'hF0F, -1, -1);
        run_frame(1'b0, 2'd0, 1'b0, 8'h12, 8'h34, 12'h14A, -1, -1);
        // Overlong line sets a sticky error
        chk("line_err_clear", 32'(line_err), 32'h0);
        run_frame(1'b0, 2'd0, 1'b0, 8'hF8, 8'h1F, 12'hF0F, 1, -1);
        chk("line_err_set", 32'(line_err), 32'h1);
        run_frame(1'b0, 2'd1, 1'b0, 8'h12, 8'h34, 12'h14A, -1, -1);
        chk("line_err_sticky", 32'(line_err), 32'h1);
        // Reset after the 5th write, then a clean frame from addr 0 in bank 0
        run_frame(1'b0, 2'd0, 1'b0, 8'hF8, 8'h1F, 12'hF0F, -1, 5);
        chk("line_err_after_rst", 32'(line_err), 32'h0);
        run_frame(1'b1, 2'd0, 1'b0, 8'h0A, 8'hBC, 12'hABC, -1, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
